// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: config-region decode
// constants and the byte-lane merge helper used by RAM-side and config writes.
package data_sram_responder_pkg;

    // Default value of addr[31:16] that selects the config region
    localparam logic [15:0] CONF_BASE_DEFAULT = 16'hBFAF;

    // Config register offsets within the region (addr[15:0])
    localparam logic [15:0] LED_OFF    = 16'h0000;
    localparam logic [15:0] TIMER_OFF  = 16'h0004;
    localparam logic [15:0] CMP_OFF    = 16'h0008;
    localparam logic [15:0] STATUS_OFF = 16'h000C;

    // Replace each byte of old whose wen bit is set with the matching wdata byte
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : data_sram_responder_pkg

// File: rtl/data_sram_responder_if.sv
// Core-to-responder data-SRAM port. The core drives requests (master); the
// responder returns registered read data (slave).
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface : data_sram_responder_if

// File: rtl/data_sram_responder_bytewrite_ram.sv
// 2^AW x 32 synchronous RAM with per-byte write enables. Read-first: an
// access returns the word as it was before any same-edge write.
module bytewrite_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [3:0]    i_wen,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [2**AW];
    logic [31:0] r_rdata;

    // Byte-lane writes into the array
    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wen[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port, updated on every access and held otherwise
    // NOTE: non-blocking assignment samples the pre-write word, which is what makes this read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : bytewrite_ram

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM port: word RAM with byte writes plus a
// config region holding LEDs, a free-running timer, a compare register and a
// sticky compare interrupt. Read data is registered (one-cycle latency).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          AW        = 12,
    parameter logic [15:0] CONF_BASE = CONF_BASE_DEFAULT,
    parameter int          LED_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave io_sram,
    output logic [LED_W-1:0]     o_led,
    output logic                 o_timer_irq
);

    logic             w_conf_sel;
    logic [15:0]      w_offset;
    logic             w_write;
    logic             w_ram_en;
    logic             w_conf_req;
    logic             w_led_wr;
    logic             w_timer_wr;
    logic             w_cmp_wr;
    logic             w_status_wr;
    logic             w_irq_set;
    logic [31:0]      w_led_ext;
    logic [31:0]      w_conf_rdata;
    logic [31:0]      w_ram_rdata;

    logic [LED_W-1:0] r_led;
    logic [31:0]      r_timer;
    logic [31:0]      r_cmp;
    logic             r_irq;
    logic [31:0]      r_conf_rdata;
    logic             r_rsel_conf;

    // Address decode and per-register write strobes
    assign w_conf_sel  = (io_sram.data_sram_addr[31:16] == CONF_BASE);
    assign w_offset    = io_sram.data_sram_addr[15:0];
    assign w_write     = (io_sram.data_sram_wen != 4'b0000);
    assign w_ram_en    = io_sram.data_sram_en && !w_conf_sel;
    assign w_conf_req  = io_sram.data_sram_en && w_conf_sel;
    assign w_led_wr    = w_conf_req && w_write && (w_offset == LED_OFF);
    assign w_timer_wr  = w_conf_req && w_write && (w_offset == TIMER_OFF);
    assign w_cmp_wr    = w_conf_req && w_write && (w_offset == CMP_OFF);
    assign w_status_wr = w_conf_req && w_write && (w_offset == STATUS_OFF);
    assign w_irq_set   = (r_timer == r_cmp) && (r_cmp != 32'd0);

    bytewrite_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_ram_en),
        .i_wen   (io_sram.data_sram_wen),
        .i_addr  (io_sram.data_sram_addr[AW+1:2]),
        .i_wdata (io_sram.data_sram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Zero-extend the LED register to a bus word and select the config read value
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        w_led_ext              = '0;
        w_led_ext[LED_W-1:0]   = r_led;
        w_conf_rdata           = '0;
        case (w_offset)
            LED_OFF:    w_conf_rdata = w_led_ext;
            TIMER_OFF:  w_conf_rdata = r_timer;
            CMP_OFF:    w_conf_rdata = r_cmp;
            STATUS_OFF: w_conf_rdata = {31'b0, r_irq};
            default:    w_conf_rdata = '0;
        endcase
    end

    // Registered config read data and source select; both hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conf_rdata <= '0;
            r_rsel_conf  <= 1'b0;
        end else if (io_sram.data_sram_en) begin
            r_rsel_conf <= w_conf_sel;
            if (w_conf_sel) begin
                r_conf_rdata <= w_conf_rdata;
            end
        end
    end

    // LED register, byte-merged through the low lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else if (w_led_wr) begin
            r_led <= LED_W'(byte_merge(w_led_ext, io_sram.data_sram_wdata, io_sram.data_sram_wen));
        end
    end

    // Free-running timer; a write loads the merged value instead of incrementing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_timer_wr) begin
            r_timer <= byte_merge(r_timer, io_sram.data_sram_wdata, io_sram.data_sram_wen);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Timer compare register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp <= '0;
        end else if (w_cmp_wr) begin
            r_cmp <= byte_merge(r_cmp, io_sram.data_sram_wdata, io_sram.data_sram_wen);
        end
    end

    // Sticky interrupt: a compare match beats a same-cycle STATUS clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (w_status_wr) begin
            r_irq <= 1'b0;
        end
    end

    assign io_sram.data_sram_rdata = r_rsel_conf ? r_conf_rdata : w_ram_rdata;
    assign o_led                   = r_led;
    assign o_timer_irq             = r_irq;

endmodule : data_sram_responder

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder. Reads push their expected word
// onto a scoreboard queue when issued; the word is popped and compared against
// rdata one cycle later. Other observations are checked inline per scenario.
module tb_data_sram_responder;

    localparam logic [31:0] A_LED    = 32'hBFAF_0000;
    localparam logic [31:0] A_TIMER  = 32'hBFAF_0004;
    localparam logic [31:0] A_CMP    = 32'hBFAF_0008;
    localparam logic [31:0] A_STATUS = 32'hBFAF_000C;
    localparam logic [31:0] A_HOLE   = 32'hBFAF_0010;

    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic        timer_irq;

    int n_checks;
    int n_fail;

    logic [31:0] exp_q  [$];
    string       name_q [$];

    data_sram_responder_if sram ();

    data_sram_responder #(
        .AW        (12),
        .CONF_BASE (16'hBFAF),
        .LED_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_sram     (sram.slave),
        .o_led       (led),
        .o_timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: present the request, let the edge take it, then go idle
    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        sram.data_sram_en    = 1'b1;
        sram.data_sram_wen   = wen;
        sram.data_sram_addr  = addr;
        sram.data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        sram.data_sram_en    = 1'b0;
        sram.data_sram_wen   = 4'b0000;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen);
        access(wen, addr, wdata);
    endtask

    // Read: expectation is queued at issue and popped when rdata becomes valid
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] e;
        string       nm;
        exp_q.push_back(exp);
        name_q.push_back(name);
        access(4'b0000, addr, 32'h0);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, rdata=%08h", name, sram.data_sram_rdata);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (sram.data_sram_rdata !== e) begin
                n_fail++;
                $display("FAIL %s: rdata=%08h expected=%08h", nm, sram.data_sram_rdata, e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_irq(input logic exp, input string name);
        n_checks++;
        if (timer_irq !== exp) begin
            n_fail++;
            $display("FAIL %s: timer_irq=%0b expected=%0b", name, timer_irq, exp);
        end
    endtask

    task automatic test_reset();
        rst                  = 1'b1;
        sram.data_sram_en    = 1'b0;
        sram.data_sram_wen   = 4'b0000;
        sram.data_sram_addr  = 32'h0;
        sram.data_sram_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wr(A_LED, 32'h0000_1234, 4'b1111);
        rd(A_LED, 32'h0000_1234, "led_pre_reset");
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (sram.data_sram_rdata !== 32'h0 || led !== 16'h0 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: rdata=%08h led=%04h irq=%0b expected all zero",
                     sram.data_sram_rdata, led, timer_irq);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd(A_TIMER, 32'd1, "timer_after_reset");
    endtask

    task automatic test_byte_write();
        wr(32'h0000_0010, 32'h1122_3344, 4'b1111);
        wr(32'h0000_0010, 32'h0000_00AA, 4'b0001);
        rd(32'h0000_0010, 32'h1122_33AA, "byte_merge_lane0");
        wr(32'h0000_0010, 32'h0000_5500, 4'b0010);
        n_checks++;
        if (sram.data_sram_rdata !== 32'h1122_33AA) begin
            n_fail++;
            $display("FAIL write_read_first: rdata=%08h expected=%08h", sram.data_sram_rdata, 32'h1122_33AA);
        end
        rd(32'h0000_0010, 32'h1122_55AA, "byte_merge_lane1");
    endtask

    task automatic test_alias_hold();
        wr(32'h0000_4000, 32'hDEAD_BEEF, 4'b1111);
        rd(32'h0000_0000, 32'hDEAD_BEEF, "alias_wrap");
        sram.data_sram_wen   = 4'b1111;
        sram.data_sram_addr  = 32'h0000_0000;
        sram.data_sram_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (sram.data_sram_rdata !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: rdata=%08h expected=%08h", i, sram.data_sram_rdata, 32'hDEAD_BEEF);
            end
        end
        sram.data_sram_wen = 4'b0000;
        rd(32'h0000_0000, 32'hDEAD_BEEF, "no_write_when_idle");
    endtask

    task automatic test_led();
        wr(A_LED, 32'hFFFF_5A5A, 4'b1111);
        n_checks++;
        if (led !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL led_write: led=%04h expected=%04h", led, 16'h5A5A);
        end
        rd(A_LED, 32'h0000_5A5A, "led_readback");
        wr(A_LED, 32'hFFFF_A5FF, 4'b0010);
        n_checks++;
        if (led !== 16'hA55A) begin
            n_fail++;
            $display("FAIL led_byte_merge: led=%04h expected=%04h", led, 16'hA55A);
        end
        wr(A_HOLE, 32'hFFFF_FFFF, 4'b1111);
        rd(A_HOLE, 32'h0000_0000, "unmapped_offset");
    endtask

    task automatic test_timer_irq();
        wr(A_TIMER, 32'hFFFF_FFFE, 4'b1111);
        wr(A_CMP, 32'h0000_0003, 4'b1111);
        rd(A_TIMER, 32'hFFFF_FFFF, "timer_before_wrap");
        rd(A_TIMER, 32'h0000_0000, "timer_wrapped");
        chk_irq(1'b0, "irq_timer_1");
        idle(1);
        chk_irq(1'b0, "irq_timer_2");
        idle(1);
        chk_irq(1'b0, "irq_timer_eq_cmp");
        idle(1);
        chk_irq(1'b1, "irq_rise");
        rd(A_STATUS, 32'h0000_0001, "status_set");
        idle(2);
        chk_irq(1'b1, "irq_sticky");
        wr(A_STATUS, 32'h0000_0000, 4'b1111);
        chk_irq(1'b0, "irq_cleared");
        rd(A_STATUS, 32'h0000_0000, "status_cleared");
    endtask

    task automatic test_timer_overlap();
        wr(A_CMP, 32'h0000_0005, 4'b1111);
        wr(A_TIMER, 32'h0000_0005, 4'b1111);
        chk_irq(1'b0, "overlap_pre");
        wr(A_STATUS, 32'h0000_0000, 4'b1111);
        chk_irq(1'b1, "overlap_set_wins");
        rd(A_STATUS, 32'h0000_0001, "overlap_status");
        wr(A_STATUS, 32'h0000_0000, 4'b0001);
        chk_irq(1'b0, "overlap_clear");
    endtask

    task automatic test_cmp_zero();
        wr(A_CMP, 32'h0000_0000, 4'b1111);
        wr(A_TIMER, 32'hFFFF_FFFE, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk_irq(1'b0, "cmp_zero_no_irq");
        end
        rd(A_CMP, 32'h0000_0000, "cmp_readback");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_byte_write();
        test_alias_hold();
        test_led();
        test_timer_irq();
        test_timer_overlap();
        test_cmp_zero();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_sram_responder
